// File: rtl/vga_scan_driver_pkg.sv
// Shared VGA timing constants and the colour type exchanged with the renderers.
// Horizontal/vertical porch and sync widths are fixed; the visible sizes may be overridden per instance.
package vga_pkg;

    localparam int CNT_W     = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Inclusive range test on a scan counter.
    function automatic logic in_span(logic [CNT_W-1:0] v,
                                     logic [CNT_W-1:0] lo,
                                     logic [CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_scan_driver_if.sv
// Pixel bus between the scan driver, the renderer mux (x/y out, rgb back) and the DAC pins.
interface vga_scan_driver_if;

    logic [7:0] rgb_r;
    logic [7:0] rgb_g;
    logic [7:0] rgb_b;

    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       frame_start;

    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic       vga_sync_n;
    logic       vga_clk;

    modport master (
        input  rgb_r, rgb_g, rgb_b,
        output x, y, video_on, frame_start,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk
    );

    modport slave (
        output rgb_r, rgb_g, rgb_b,
        input  x, y, video_on, frame_start,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk
    );

endinterface

// File: rtl/vga_scan_driver_pixel_tick.sv
// System-clock to pixel-rate divider: one-clk pix_tick per pixel and a 50% duty DAC clock.
module vga_pixel_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick_o,
    output logic vga_clk_o
);

    localparam int            DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    if (CLK_DIV != 2 && CLK_DIV != 4) begin : g_bad_div
        $error("vga_pixel_tick: CLK_DIV must be 2 or 4");
    end

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;
    logic          vga_clk_q;

    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
    end

    // vga_clk is registered from the next divider value so it always equals
    // (div_cnt >= CLK_DIV/2); its rising edge lands mid-pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            vga_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            vga_clk_q <= (div_cnt_d >= DIV_HALF);
        end
    end

    assign pix_tick_o = (div_cnt_q == DIV_LAST);
    assign vga_clk_o  = vga_clk_q;

endmodule

// File: rtl/vga_scan_driver.sv
// 640x480@60 raster scan: presents (x, y) to the renderers and registers colour, sync
// and blank together one pixel later so everything reaching the DAC stays aligned.
module vga_scan_driver #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_scan_driver_if.master  bus
);

    import vga_pkg::*;

    localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic pix_tick;
    logic vga_clk;

    vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_tick_o (pix_tick),
        .vga_clk_o  (vga_clk)
    );

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             h_wrap, v_wrap;
    logic             video_on;

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        v_wrap  = (v_cnt_q == V_LAST);
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_tick) begin
            if (h_wrap) begin
                h_cnt_d = '0;
                v_cnt_d = v_wrap ? '0 : v_cnt_q + CNT_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end
        end
        video_on = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    end

    rgb888_t pix_in, pix_q;
    logic    hs_q, vs_q, blank_n_q;

    assign pix_in = '{r: bus.rgb_r, g: bus.rgb_g, b: bus.rgb_b};

    // Output stage samples the renderer at the last clk of the pixel, after
    // CLK_DIV-1 clks of settling on a stable (x, y).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            pix_q     <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            if (pix_tick) begin
                hs_q      <= ~in_span(h_cnt_q, HS_LO, HS_HI);
                vs_q      <= ~in_span(v_cnt_q, VS_LO, VS_HI);
                blank_n_q <= video_on;
                pix_q     <= video_on ? pix_in : '0;
            end
        end
    end

    assign bus.x           = h_cnt_q;
    assign bus.y           = v_cnt_q;
    assign bus.video_on    = video_on;
    assign bus.frame_start = pix_tick && h_wrap && v_wrap;
    assign bus.vga_r       = pix_q.r;
    assign bus.vga_g       = pix_q.g;
    assign bus.vga_b       = pix_q.b;
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.vga_blank_n = blank_n_q;
    assign bus.vga_sync_n  = 1'b0;
    assign bus.vga_clk     = vga_clk;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Scan driver bench: per-clk compare of every output against a pixel-count reference model,
// plus sync widths/positions, frame_start timing and async mid-scan reset.
module tb_vga_scan_driver;

    localparam int CD  = 2;
    localparam int HV  = 640;
    localparam int VV  = 2;    // short frame keeps a full-frame run affordable
    localparam int HT  = HV + 16 + 96 + 48;
    localparam int VT  = VV + 10 + 2 + 33;
    localparam int HSW = 96 * CD;
    localparam int VSW = 2 * HT * CD;

    logic clk;
    logic rst_n;

    vga_scan_driver_if bus();

    vga_scan_driver #(.CLK_DIV(CD), .H_VISIBLE(HV), .V_VISIBLE(VV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n;
    int unsigned nvec, nerr;
    bit          mode;
    logic [31:0] key;
    int unsigned hs_run, vs_run, hs_first, vs_first, fs_first, fs_cnt;

    // Renderer stub: mode 0 gives r = x[7:0] and keyed patterns on g/b, mode 1 is solid white.
    function automatic logic [23:0] render(int unsigned x, int unsigned y, bit m, logic [31:0] k);
        logic [7:0] xb, yb;
        xb = 8'(x);
        yb = 8'(y);
        if (m) return 24'hFFFFFF;
        return {xb, yb ^ k[7:0], 8'(xb + 8'(yb * 8'd3)) ^ k[15:8]};
    endfunction

    always_comb begin
        {bus.rgb_r, bus.rgb_g, bus.rgb_b} = render({22'b0, bus.x}, {22'b0, bus.y}, mode, key);
    end

    // Expected outputs after c clk edges since reset release.
    function automatic logic [63:0] model(int unsigned c);
        int unsigned d, p, x, y, xq, yq;
        logic pt, vis, visq, hs, vs, fs;
        logic [23:0] col;
        d   = c % CD;
        p   = c / CD;
        x   = p % HT;
        y   = (p / HT) % VT;
        pt  = (d == CD - 1);
        vis = (x < HV) && (y < VV);
        fs  = pt && (x == HT - 1) && (y == VT - 1);
        if (p == 0) begin
            hs = 1'b1; vs = 1'b1; visq = 1'b0; col = '0;
        end else begin
            xq   = (p - 1) % HT;
            yq   = ((p - 1) / HT) % VT;
            hs   = !(xq >= HV + 16 && xq < HV + 16 + 96);
            vs   = !(yq >= VV + 10 && yq < VV + 12);
            visq = (xq < HV) && (yq < VV);
            col  = visq ? render(xq, yq, mode, key) : 24'h0;
        end
        return {13'b0, 10'(x), 10'(y), vis, fs, col, hs, vs, visq, 1'b0, (d >= CD / 2)};
    endfunction

    function automatic logic [63:0] obs();
        return {13'b0, bus.x, bus.y, bus.video_on, bus.frame_start,
                bus.vga_r, bus.vga_g, bus.vga_b, bus.vga_hs, bus.vga_vs,
                bus.vga_blank_n, bus.vga_sync_n, bus.vga_clk};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s at clk %0d: got %h expected %h", tag, n, got, exp);
        end
    endtask

    task automatic clr_stats();
        hs_run = 0; vs_run = 0; hs_first = 0; vs_first = 0; fs_first = 0; fs_cnt = 0;
    endtask

    task automatic run(input int unsigned clks);
        repeat (clks) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            chk("scan", obs(), model(n));
            if (!bus.vga_hs) begin
                if (hs_first == 0) hs_first = n;
                hs_run++;
            end else if (hs_run != 0) begin
                chk("hs_width", 64'(hs_run), 64'(HSW));
                hs_run = 0;
            end
            if (!bus.vga_vs) begin
                if (vs_first == 0) vs_first = n;
                vs_run++;
            end else if (vs_run != 0) begin
                chk("vs_width", 64'(vs_run), 64'(VSW));
                vs_run = 0;
            end
            if (bus.frame_start) begin
                if (fs_cnt == 0) fs_first = n;
                fs_cnt++;
            end
        end
    endtask

    task automatic hold_reset(input int unsigned clks);
        n = 0;
        repeat (clks) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_hold", obs(), model(0));
        end
    endtask

    initial begin
        nvec = 0; nerr = 0; n = 0;
        mode = 1'b0;
        key  = $urandom;
        clr_stats();
        rst_n = 1'b0;
        hold_reset(3 + $urandom_range(0, 3));
        rst_n = 1'b1;

        // Patterned colour through line 0 (r = x mod 256) and into line 1.
        run(CD * (HT + 400));
        chk("pre_rst_x", 64'(bus.x), 64'd400);

        // Asynchronous reset mid-scan must take effect before the next edge.
        #1 rst_n = 1'b0;
        #1 chk("async_rst", obs(), model(0));
        @(negedge clk);
        hold_reset(3);

        mode = 1'b1;
        key  = $urandom;
        clr_stats();
        rst_n = 1'b1;
        run(CD * HT * VT + 20);

        chk("hs_first", 64'(hs_first), 64'(CD * (HV + 16 + 1)));
        chk("vs_first", 64'(vs_first), 64'(CD * (HT * (VV + 10) + 1)));
        chk("fs_first", 64'(fs_first), 64'(CD * HT * VT - 1));
        chk("fs_count", 64'(fs_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/vga_scan_driver.md
Name: vga_scan_driver

Overview:
Drives the VGA display side of the pixel interface used by the screen renderers such as the end-of-game winner screen.
- Generates the 640x480@60 Hz raster scan and presents the current pixel coordinates (x, y) to the combinational renderers.
- Captures their returned r/g/b colour each pixel, gated by blanking.
- Emits sync, blank and pixel-clock signals aligned to the captured colour for the DAC.
- Sits between the top-level renderer mux and the board VGA pins.

Parameters:
CLK_DIV, 2, system clocks per pixel; legal values are 2 and 4 (50 MHz -> 25 MHz with the default).
H_VISIBLE, 640, active pixels per line.
V_VISIBLE, 480, active lines per frame.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous reset, active-low.
rgb_r  in  8  red from renderer for current (x, y).
rgb_g  in  8  green from renderer.
rgb_b  in  8  blue from renderer.
x  out  10  current horizontal count (0..799).
y  out  10  current vertical count (0..524).
video_on  out  1  high when x<640 and y<480 (combinational from counters).
frame_start  out  1  one-clk pulse at the end of each frame.
vga_r  out  8  registered red to DAC.
vga_g  out  8  registered green to DAC.
vga_b  out  8  registered blue to DAC.
vga_hs  out  1  horizontal sync, active-low.
vga_vs  out  1  vertical sync, active-low.
vga_blank_n  out  1  DAC blank, low during blanking.
vga_sync_n  out  1  constant 0 (no sync-on-green).
vga_clk  out  1  DAC pixel clock.

Behaviour:
- Reset (rst_n low, asynchronous): div_cnt=0, h_cnt=0, v_cnt=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, vga_clk=0, frame_start=0. While in reset, x=y=0 and video_on=1.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_tick = (div_cnt==CLK_DIV-1), high for exactly one clk per pixel.
- vga_clk: registered, equals (div_cnt >= CLK_DIV/2), giving a 50% duty cycle. Its rising edge falls mid-pixel, so DAC data are stable around it.
- Horizontal timing (total 800):
  - visible 0..639
  - front porch 640..655
  - sync 656..751
  - back porch 752..799
- Vertical timing (total 525):
  - visible 0..479
  - front porch 480..489
  - sync 490..491
  - back porch 492..524
- Counter stepping, on pix_tick only:
  - h_cnt increments.
  - At h_cnt=799, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt=524 together with h_cnt=799, both counters wrap to 0.
- x, y: x=h_cnt and y=v_cnt. Both are held constant for the full CLK_DIV period, so the renderers have CLK_DIV-1 cycles of settling time.
- Output stage, registered on pix_tick (1-pixel latency relative to x/y):
  - vga_hs <= ~(656<=h_cnt<=751)
  - vga_vs <= ~(490<=v_cnt<=491)
  - vga_blank_n <= video_on
  - vga_r/g/b <= video_on ? rgb : 0
- All DAC outputs share the same one-pixel delay, so colour, sync and blank stay mutually aligned.
- Blanking: any rgb value presented outside the visible region must never reach vga_r/g/b.
- frame_start: equals pix_tick && h_cnt==799 && v_cnt==524. It is a single clk-wide pulse, coincident with the wrap. Downstream logic (e.g. game-state latch) uses it to update ganador between frames.
- Mid-operation reset: all state returns to reset values immediately. After release, the first pix_tick occurs CLK_DIV clks later and the scan restarts at (0,0).
- Widths: counters are 10 bits. Compare constants must not be truncated, since 799 fits in 10 bits.

Decomposition:
- Shared package vga_pkg holds:
  - timing localparams: H_VISIBLE, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800, V_VISIBLE, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525
  - a packed rgb888_t struct {r, g, b}
- One sub-module, vga_pixel_tick, contains the divider, pix_tick and vga_clk.
- Counters and the output stage stay in vga_scan_driver.

Test Plan:
- Reset, then release; count clks -> first pix_tick at clk 2 (CLK_DIV=2), and 800*525*2=840000 clks between frame_start pulses.
- Observe one line -> vga_hs low for exactly 96 pixels (192 clks). The falling edge occurs one pixel after x=656.
- Observe one frame -> vga_vs low for exactly 2 lines (1600 pixels), starting one pixel after (x=0, y=490).
- Renderer stub returns rgb=FF/FF/FF always:
  - x=639 -> vga_r=FF on the next pixel.
  - x=640 -> vga_r=00 and vga_blank_n=0 on the next pixel.
  - y=480 -> blanked for the whole line.
- Renderer stub returns r=x[7:0] -> vga_r at pixel n+1 equals n mod 256 for n=0..639; no off-by-one.
- Assert rst_n low at (x=400, y=300) for 3 clks -> outputs reset at once (async). After release, the scan restarts at (0,0) and vga_hs=1, vga_vs=1.
